// File: rtl/ehgu_clksw_pkg.sv
// Shared types and defaults for the clock-switch request controller.
package ehgu_clksw_pkg;

  localparam int NREQ_DEFAULT          = 4;
  localparam int SETTLE_CYCLES_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/ehgu_clksw_ctrl_if.sv
// Requester-side bundle of the clock-switch controller: requests in, grants and mux select out.
interface ehgu_clksw_ctrl_if
  import ehgu_clksw_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_sel;
  logic [NREQ-1:0] gnt;
  logic            sel;
  logic            busy;

  modport master (
    output req,
    output req_sel,
    input  gnt,
    input  sel,
    input  busy
  );

  modport slave (
    input  req,
    input  req_sel,
    output gnt,
    output sel,
    output busy
  );

endinterface

// File: rtl/ehgu_rr_arb.sv
// Combinational round-robin arbiter: search begins one past the last granted index.
module ehgu_rr_arb
  import ehgu_clksw_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [NREQ-1:0]  winner
);

  localparam logic [PTR_W:0] NREQ_W = (PTR_W + 1)'(NREQ);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // sum never exceeds 2*NREQ-1, so a single conditional subtract wraps it
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last_ptr} + (PTR_W + 1)'(k);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ehgu_clksw_ctrl.sv
// Arbitrates clock-source switch requests, drives the glitch-free mux select and
// grants each requester once the mux has had SETTLE_CYCLES to settle.
module ehgu_clksw_ctrl
  import ehgu_clksw_pkg::*;
#(
  parameter int NREQ          = NREQ_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  ehgu_clksw_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NREQ - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sel_reg, sel_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic             busy_reg;
  logic [NREQ-1:0]  win_reg, win_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;

  logic [NREQ-1:0]  arb_win;
  logic             arb_sel;
  logic [PTR_W-1:0] win_idx;

  ehgu_rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req      (bus.req),
    .last_ptr (ptr_reg),
    .winner   (arb_win)
  );

  assign arb_sel = |(bus.req_sel & arb_win);

  // one-hot latched winner to index: bit gi of the index ORs every winner bit whose position has bit gi set
  genvar gi, gj;
  generate
    for (gi = 0; gi < PTR_W; gi++) begin : g_enc
      logic [NREQ-1:0] mask;
      for (gj = 0; gj < NREQ; gj++) begin : g_bit
        assign mask[gj] = ((gj >> gi) & 1) != 0;
      end
      assign win_idx[gi] = |(win_reg & mask);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    gnt_next   = '0;
    win_next   = win_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|bus.req) begin
          win_next = arb_win;
          if (arb_sel == sel_reg) begin
            state_next = ST_ACK;
            gnt_next   = arb_win;
          end else begin
            state_next = ST_SETTLE;
            sel_next   = arb_sel;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == '0) begin
          state_next = ST_ACK;
          gnt_next   = win_reg;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
        ptr_next   = win_idx;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // gnt is loaded on entry to ACK so it is a pure flop output that lasts exactly the ACK cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      sel_reg   <= 1'b0;
      gnt_reg   <= '0;
      busy_reg  <= 1'b0;
      win_reg   <= '0;
      ptr_reg   <= PTR_RST;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      gnt_reg   <= gnt_next;
      busy_reg  <= (state_next != ST_IDLE);
      win_reg   <= win_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign bus.sel  = sel_reg;
  assign bus.gnt  = gnt_reg;
  assign bus.busy = busy_reg;

endmodule
